// File: rtl/pm_loader.sv
// pm_loader: serial byte loader for program memory.
// Collects DATAWIDTH/8 bytes per word (little-endian), writes each word with a
// single-cycle pm_wr_en strobe at an auto-incrementing address, and signals
// session completion with a one-cycle done pulse.
// Optional feature: define PM_LOADER_CHECKSUM_EN to expect one trailing
// checksum byte (XOR of all data bytes) per session; a mismatch sets chk_err.
module pm_loader #(
  parameter int DATAWIDTH = 32,
  parameter int ADDWIDTH  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic [ADDWIDTH-1:0]  load_addr,
  input  logic [ADDWIDTH-1:0]  load_count,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 pm_wr_en,
  output logic [ADDWIDTH-1:0]  pm_addr,
  output logic [DATAWIDTH-1:0] pm_data,
  output logic                 busy,
  output logic                 done,
  output logic                 chk_err
);

  localparam int NBYTES = DATAWIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
`ifdef PM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t                 state;
  logic [ADDWIDTH-1:0]    cur_addr;
  logic [ADDWIDTH-1:0]    remaining;
  logic [IDXW-1:0]        idx;
  logic [DATAWIDTH-1:0]   word_buf;
  logic [DATAWIDTH-1:0]   word_next;
  logic                   xfer;

`ifdef PM_LOADER_CHECKSUM_EN
  logic [7:0]             csum;
  logic                   chk_err_q;
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign xfer = byte_valid && byte_ready;

  // Word as it will look once the byte currently on byte_in is merged in;
  // used so the last byte of a word reaches pm_data in the same edge.
  always_comb begin
    word_next = word_buf;
    word_next[8*int'(idx) +: 8] = byte_in;
  end

  // Session FSM with registered handshake, memory-write and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      idx        <= '0;
      word_buf   <= '0;
      byte_ready <= 1'b0;
      pm_wr_en   <= 1'b0;
      pm_addr    <= '0;
      pm_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef PM_LOADER_CHECKSUM_EN
      csum       <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      pm_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
`ifdef PM_LOADER_CHECKSUM_EN
            chk_err_q <= 1'b0;
`endif
            if (load_count != '0) begin
              cur_addr   <= load_addr;
              remaining  <= load_count;
              idx        <= '0;
`ifdef PM_LOADER_CHECKSUM_EN
              csum       <= '0;
`endif
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              state      <= COLLECT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end

        COLLECT: begin
          if (xfer) begin
            word_buf <= word_next;
`ifdef PM_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_in;
`endif
            if (idx == LAST_IDX) begin
              idx        <= '0;
              byte_ready <= 1'b0;
              pm_wr_en   <= 1'b1;
              pm_addr    <= cur_addr;
              pm_data    <= word_next;
              state      <= WRITE;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end

        WRITE: begin
          cur_addr  <= cur_addr + ADDWIDTH'(1);
          remaining <= remaining - ADDWIDTH'(1);
          if (remaining == ADDWIDTH'(1)) begin
`ifdef PM_LOADER_CHECKSUM_EN
            byte_ready <= 1'b1;
            state      <= CHECK;
`else
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`endif
          end else begin
            byte_ready <= 1'b1;
            state      <= COLLECT;
          end
        end

`ifdef PM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            chk_err_q  <= (byte_in != csum);
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader (default parameters).
// Expected writes are derived from the session request and byte list:
// word w goes to (addr + w) mod 128 and holds bytes 4w..4w+3 little-endian.
module tb_pm_loader;

  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW-1:0] load_addr;
  logic [AW-1:0] load_count;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          pm_wr_en;
  logic [AW-1:0] pm_addr;
  logic [DW-1:0] pm_data;
  logic          busy;
  logic          done;
  logic          chk_err;

  pm_loader #(.DATAWIDTH(DW), .ADDWIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_addr  (load_addr),
    .load_count (load_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .pm_wr_en   (pm_wr_en),
    .pm_addr    (pm_addr),
    .pm_data    (pm_data),
    .busy       (busy),
    .done       (done),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start_cyc;
  int last_xfer_cyc;

  always @(posedge clk) cyc++;

  // Observed activity, sampled on the falling edge.
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            ready_in_write = 0;

  always @(negedge clk) begin
    if (pm_wr_en) begin
      wr_addr_q.push_back(pm_addr);
      wr_data_q.push_back(pm_data);
      wr_cyc_q.push_back(cyc);
      if (byte_ready) ready_in_write++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [DW-1:0] model_word(input logic [7:0] b[$], input int w);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < DW/8; k++) v = v + (DW'(b[(DW/8)*w + k]) << (8*k));
    return v;
  endfunction

  function automatic logic [7:0] model_xor(input logic [7:0] b[$]);
    logic [7:0] x;
    x = '0;
    foreach (b[i]) x = x ^ b[i];
    return x;
  endfunction

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic start_load(input logic [AW-1:0] a, input logic [AW-1:0] c);
    @(negedge clk);
    load_start = 1'b1;
    load_addr  = a;
    load_count = c;
    start_cyc  = cyc;
    @(negedge clk);
    load_start = 1'b0;
    load_addr  = AW'($urandom);
    load_count = AW'($urandom);
  endtask

  // Offers bytes from a falling edge on; a byte counts as taken when
  // byte_ready is high while it is offered. Idle cycles carry junk data.
  task automatic feed(input logic [7:0] q[$], input int gap);
    int i = 0;
    int guard = 0;
    while (i < q.size() && guard < 2000) begin
      if (gap > 0 && $urandom_range(0, gap) != 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in    = q[i];
        if (byte_ready) begin
          i++;
          last_xfer_cyc = cyc;
        end
      end
      @(negedge clk);
      guard++;
    end
    byte_valid = 1'b0;
    if (guard >= 2000) begin
      errors++;
      $display("FAIL feed_timeout: accepted %0d of %0d bytes", i, q.size());
    end
  endtask

  task automatic send_trailer(input logic [7:0] b[$], input logic [7:0] ck_flip);
`ifdef PM_LOADER_CHECKSUM_EN
    logic [7:0] t[$];
    t.push_back(model_xor(b) ^ ck_flip);
    feed(t, 0);
`else
    if (b.size() < 0 || ck_flip != ck_flip) byte_valid = 1'b0;
`endif
  endtask

  task automatic wait_done(input int d0, input string name);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_done_timeout: no done pulse within %0d cycles", name, n);
    end
  endtask

  task automatic check_writes(input logic [AW-1:0] a, input int c,
                              input logic [7:0] b[$], input string name);
    checks++;
    if (wr_addr_q.size() !== c) begin
      errors++;
      $display("FAIL %s_nwrites: got %0d want %0d", name, wr_addr_q.size(), c);
    end
    for (int w = 0; w < c && w < wr_addr_q.size(); w++) begin
      checks++;
      if (wr_addr_q[w] !== AW'((int'(a) + w) % (1 << AW))) begin
        errors++;
        $display("FAIL %s_addr[%0d]: got %h want %h", name, w, wr_addr_q[w],
                 AW'((int'(a) + w) % (1 << AW)));
      end
      checks++;
      if (wr_data_q[w] !== model_word(b, w)) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h want %h", name, w, wr_data_q[w], model_word(b, w));
      end
    end
  endtask

  task automatic do_session(input logic [AW-1:0] a, input int c, input logic [7:0] b[$],
                            input int gap, input logic [7:0] ck_flip, input string name);
    int d0;
    clear_obs();
    d0 = done_cnt;
    start_load(a, AW'(c));
    feed(b, gap);
    send_trailer(b, ck_flip);
    wait_done(d0, name);
    check_writes(a, c, b, name);
    @(negedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 + 1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: done_pulses=%0d done=%b busy=%b want 1,0,0",
               name, done_cnt - d0, done, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({byte_ready, pm_wr_en, busy, done, chk_err} !== 5'b0 || pm_addr !== '0 || pm_data !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h want all 0",
               byte_ready, pm_wr_en, busy, done, chk_err, pm_addr, pm_data);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] b[$];
    b = {8'h13, 8'h05, 8'h10, 8'h00};
    do_session(7'h05, 1, b, 0, 8'h00, "single");
    checks++;
    if (wr_data_q.size() == 1 && wr_data_q[0] !== 32'h00100513) begin
      errors++;
      $display("FAIL single_word: got %h want 00100513", wr_data_q[0]);
    end
    checks++;
    if (wr_cyc_q.size() != 1 || wr_cyc_q[0] !== last_xfer_cyc + 1) begin
      errors++;
      $display("FAIL single_latency: write cycle %0d want %0d",
               (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, last_xfer_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b[$];
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    do_session(7'h7F, 2, b, 2, 8'h00, "wrap");
`ifndef PM_LOADER_CHECKSUM_EN
    checks++;
    if (wr_cyc_q.size() != 2 || done_cyc !== wr_cyc_q[1] + 1) begin
      errors++;
      $display("FAIL wrap_done_timing: done cycle %0d want one after last write", done_cyc);
    end
`endif
  endtask

  task automatic test_stream();
    logic [7:0] b[$];
    int r0;
    b = {8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    r0 = ready_in_write;
    do_session(7'h30, 2, b, 0, 8'h00, "stream");
    checks++;
    if (ready_in_write !== r0) begin
      errors++;
      $display("FAIL stream_ready_in_write: %0d write cycles with byte_ready high, want 0",
               ready_in_write - r0);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      logic [7:0] b[$];
      int c;
      logic [AW-1:0] a;
      c = $urandom_range(1, 5);
      a = AW'($urandom);
      for (int i = 0; i < 4*c; i++) b.push_back(8'($urandom));
      do_session(a, c, b, $urandom_range(0, 3), 8'h00, "random");
    end
  endtask

  task automatic test_zero_count();
    int d0;
    clear_obs();
    d0 = done_cnt;
    start_load(7'h22, 7'h00);
    #1;
    checks++;
    if (done_cnt !== d0 + 1 || done_cyc !== start_cyc + 1) begin
      errors++;
      $display("FAIL zero_done: pulses=%0d at cycle %0d want 1 at %0d",
               done_cnt - d0, done_cyc, start_cyc + 1);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_addr_q.size() !== 0 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL zero_nowrite: writes=%0d pulses=%0d want 0,1", wr_addr_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] b[$];
    logic [7:0] h1[$];
    logic [7:0] h2[$];
    int d0;
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) h1.push_back(b[i]);
    for (int i = 3; i < 8; i++) h2.push_back(b[i]);
    clear_obs();
    d0 = done_cnt;
    start_load(7'h10, 7'd2);
    feed(h1, 0);
    load_start = 1'b1;
    load_addr  = 7'h40;
    load_count = 7'd5;
    @(negedge clk);
    load_start = 1'b0;
    feed(h2, 1);
    send_trailer(b, 8'h00);
    wait_done(d0, "busy");
    repeat (3) @(negedge clk);
    #1;
    check_writes(7'h10, 2, b, "busy");
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    b = {8'h5A, 8'hC3};
    clear_obs();
    start_load(7'h20, 7'd1);
    feed(b, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_ready, pm_wr_en, busy, done, chk_err} !== 5'b0 || pm_addr !== '0 || pm_data !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h want all 0",
               byte_ready, pm_wr_en, busy, done, chk_err, pm_addr, pm_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wr_addr_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_nowrite: writes=%0d busy=%b want 0,0", wr_addr_q.size(), busy);
    end
    b = {8'h01, 8'h23, 8'h45, 8'h67};
    do_session(7'h21, 1, b, 1, 8'h00, "after_reset");
  endtask

`ifdef PM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] b[$];
    b = {8'h11, 8'h22, 8'h44, 8'h88};
    do_session(7'h00, 1, b, 0, 8'h00, "ck_good");
    checks++;
    if (chk_err !== 1'b0) begin
      errors++;
      $display("FAIL ck_good: chk_err=%b want 0", chk_err);
    end
    do_session(7'h00, 1, b, 0, 8'hFF, "ck_bad");
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (chk_err !== 1'b1) begin
      errors++;
      $display("FAIL ck_bad_sticky: chk_err=%b want 1", chk_err);
    end
    start_load(7'h01, 7'd1);
    #1;
    checks++;
    if (chk_err !== 1'b0) begin
      errors++;
      $display("FAIL ck_clear_on_start: chk_err=%b want 0", chk_err);
    end
    feed(b, 0);
    send_trailer(b, 8'h00);
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_addr  = '0;
    load_count = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_single_word();
    test_wrap();
    test_stream();
    test_random();
    test_zero_count();
    test_busy_ignore();
    test_reset_mid();
`ifdef PM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pm_loader.md
PM_LOADER -- requirements
Module: pm_loader

Interface
REQ-001 Parameter DATAWIDTH, default 32, program-memory word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDWIDTH, default 7, program-memory address width.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 load_start  input  1  one-cycle request to begin a load session.
REQ-006 load_addr  input  ADDWIDTH  first word address, sampled with load_start.
REQ-007 load_count  input  ADDWIDTH  number of words to load, sampled with load_start.
REQ-008 byte_in  input  8  serial instruction byte.
REQ-009 byte_valid  input  1  byte_in is valid; a byte transfers when byte_valid and byte_ready are both high.
REQ-010 byte_ready  output  1  loader can accept a byte this cycle.
REQ-011 pm_wr_en  output  1  program-memory write strobe, one cycle per word.
REQ-012 pm_addr  output  ADDWIDTH  program-memory write address.
REQ-013 pm_data  output  DATAWIDTH  assembled word.
REQ-014 busy  output  1  session in progress.
REQ-015 done  output  1  one-cycle pulse at session end.
REQ-016 chk_err  output  1  sticky checksum mismatch flag (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, COLLECT, WRITE, CHECK, DONE.
REQ-018 IDLE: byte_ready=0, busy=0; load_start with load_count!=0 SHALL latch addr/count, clear the byte index, clear chk_err and go to COLLECT; load_start with load_count=0 SHALL go directly to DONE with no writes.
REQ-019 COLLECT: byte_ready=1, busy=1; each transferred byte SHALL fill bits [8k+7:8k] of the word, k = byte index 0..DATAWIDTH/8-1 (little-endian).
REQ-020 The transfer of the last byte of a word in cycle N SHALL move to WRITE, with pm_wr_en=1 in cycle N+1 carrying the full word on pm_data and the current address on pm_addr.
REQ-021 WRITE SHALL last exactly one cycle with byte_ready=0; bytes offered then SHALL stall, not drop.
REQ-022 After WRITE the address SHALL increment modulo 2^ADDWIDTH (all-ones wraps to 0) and the remaining count SHALL decrement; nonzero remaining returns to COLLECT, zero goes to CHECK (or to DONE if CHECKSUM_EN is undefined).
REQ-023 DONE SHALL assert done for exactly one cycle, busy=0, then return to IDLE.
REQ-024 load_start while busy=1 SHALL be ignored.
REQ-025 pm_wr_en SHALL be 0 in every state except WRITE; pm_addr/pm_data SHALL hold their last values outside WRITE.
REQ-026 byte_valid gaps of any length SHALL not alter the assembled word or index.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, byte_ready=0, pm_wr_en=0, pm_addr=0, pm_data=0, busy=0, done=0, chk_err=0, index/count/checksum=0.
REQ-028 Reset during a session SHALL abandon it; partially assembled words SHALL never be written.

Configuration
REQ-029 Macro PM_LOADER_CHECKSUM_EN: when defined, a running XOR of all data bytes SHALL be kept; CHECK state SHALL accept one extra byte (byte_ready=1), set chk_err if it differs from the XOR, then go to DONE.
REQ-030 When PM_LOADER_CHECKSUM_EN is undefined, CHECK SHALL be absent, no extra byte SHALL be consumed, and chk_err SHALL be tied to 0.

Verification
REQ-031 load_start addr=0x05 count=1, bytes 0x13,0x05,0x10,0x00 back-to-back -> single pm_wr_en, pm_addr=0x05, pm_data=0x00100513, one cycle after 4th byte.
REQ-032 addr=0x7F count=2, 8 bytes -> writes at 0x7F then 0x00; done one cycle after final write (checksum off).
REQ-033 byte_valid held high continuously over 2 words -> byte_ready low during each WRITE cycle, no byte lost, 8 distinct bytes in order.
REQ-034 CHECKSUM_EN, word 0x11,0x22,0x44,0x88 then 0xFF -> chk_err=0; same word then 0x00 -> chk_err=1 held until next load_start.
REQ-035 rst_n low after 2 bytes of a word -> no pm_wr_en, all outputs zero; a fresh load afterwards writes correctly.
REQ-036 load_count=0 -> done pulse one cycle after load_start, no pm_wr_en; load_start during busy -> ignored, session completes unchanged.
